// File: rtl/brush_pkg.sv
// Shared types and defaults for the brush stamp / canvas clear write controller.
package brush_pkg;
  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam int COLOR_W = 4;
  localparam int DEF_CANVAS_W = 320;
  localparam int DEF_CANVAS_H = 240;
  localparam logic [COLOR_W-1:0] DEF_CLEAR_COLOR = 4'h0;
endpackage

// File: rtl/brush_stamp_ctrl_if.sv
// Framebuffer write port: valid/ready handshake carrying pixel address and colour.
interface brush_stamp_ctrl_if #(parameter int ADDR_W = 17);
  import brush_pkg::*;

  logic               wr_valid_out;
  logic               wr_ready_in;
  logic [ADDR_W-1:0]  wr_addr_out;
  logic [COLOR_W-1:0] wr_data_out;

  modport master (output wr_valid_out, wr_addr_out, wr_data_out, input wr_ready_in);
  modport slave  (input wr_valid_out, wr_addr_out, wr_data_out, output wr_ready_in);
endinterface

// File: rtl/brush_stamp_ctrl.sv
// Single framebuffer writer: stamps an SxS brush at the cursor or sweeps the canvas
// to CLEAR_COLOR; clear wins over draw, and a clear arriving mid-stamp is deferred.
module brush_stamp_ctrl
  import brush_pkg::*;
#(
  parameter int                 CANVAS_W    = DEF_CANVAS_W,
  parameter int                 CANVAS_H    = DEF_CANVAS_H,
  parameter int                 ADDR_W      = 17,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = DEF_CLEAR_COLOR
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               draw_req_in,
  input  logic               clear_req_in,
  input  logic [9:0]         cursor_loc_x,
  input  logic [8:0]         cursor_loc_y,
  input  logic [COLOR_W-1:0] cursor_color,
  input  logic [2:0]         stroke_width,
  brush_stamp_ctrl_if.master wr,
  output logic               busy_out,
  output logic               done_out
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

  state_t             state, state_nxt;
  logic [9:0]         x0, x0_nxt;
  logic [8:0]         y0, y0_nxt;
  logic [COLOR_W-1:0] color, color_nxt;
  logic [2:0]         sw, sw_nxt;
  logic [2:0]         dx, dx_nxt, dy, dy_nxt;
  logic               pend, pend_nxt;
  logic               valid_q, valid_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [COLOR_W-1:0] data_q, data_nxt;
  logic               busy_nxt, done_nxt;

  // Pixel coordinates are one bit wider than the cursor so x0+dx never wraps.
  logic [10:0] px;
  logic [9:0]  py;
  logic        load, handled;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      x0       <= '0;
      y0       <= '0;
      color    <= '0;
      sw       <= '0;
      dx       <= '0;
      dy       <= '0;
      pend     <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      x0       <= x0_nxt;
      y0       <= y0_nxt;
      color    <= color_nxt;
      sw       <= sw_nxt;
      dx       <= dx_nxt;
      dy       <= dy_nxt;
      pend     <= pend_nxt;
      valid_q  <= valid_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      busy_out <= busy_nxt;
      done_out <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x0_nxt    = x0;
    y0_nxt    = y0;
    color_nxt = color;
    sw_nxt    = sw;
    dx_nxt    = dx;
    dy_nxt    = dy;
    pend_nxt  = pend;
    valid_nxt = valid_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    busy_nxt  = busy_out;
    done_nxt  = 1'b0;
    px        = '0;
    py        = '0;
    load      = 1'b0;
    // A clipped pixel has valid low, so it is consumed in one cycle.
    handled   = !valid_q || wr.wr_ready_in;

    case (state)
      IDLE: begin
        if (clear_req_in || pend) begin
          state_nxt = CLEAR;
          pend_nxt  = 1'b0;
          valid_nxt = 1'b1;
          addr_nxt  = '0;
          data_nxt  = CLEAR_COLOR;
          busy_nxt  = 1'b1;
        end else if (draw_req_in) begin
          state_nxt = STAMP;
          x0_nxt    = cursor_loc_x;
          y0_nxt    = cursor_loc_y;
          color_nxt = cursor_color;
          sw_nxt    = stroke_width;
          dx_nxt    = '0;
          dy_nxt    = '0;
          data_nxt  = cursor_color;
          busy_nxt  = 1'b1;
          px        = 11'(cursor_loc_x);
          py        = 10'(cursor_loc_y);
          load      = 1'b1;
        end
      end
      STAMP: begin
        if (clear_req_in) pend_nxt = 1'b1;
        if (handled) begin
          if (dx == sw && dy == sw) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            if (dx == sw) begin
              dx_nxt = '0;
              dy_nxt = dy + 3'd1;
            end else begin
              dx_nxt = dx + 3'd1;
            end
            px   = 11'(x0) + 11'(dx_nxt);
            py   = 10'(y0) + 10'(dy_nxt);
            load = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (handled) begin
          if (addr_q == LAST_ADDR) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = addr_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      valid_nxt = (px < 11'(CANVAS_W)) && (py < 10'(CANVAS_H));
      if (valid_nxt) addr_nxt = ADDR_W'(py) * ADDR_W'(CANVAS_W) + ADDR_W'(px);
    end
  end

  assign wr.wr_valid_out = valid_q;
  assign wr.wr_addr_out  = addr_q;
  assign wr.wr_data_out  = data_q;
endmodule

// File: tb/tb_brush_stamp_ctrl.sv
// Scoreboard bench: two instances (320x240 for stamps, 8x4 for clear/arbitration).
module tb_brush_stamp_ctrl;
  typedef struct {
    bit done;
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qb[$];
  exp_t qs[$];
  bit   pv_stall[2];
  int   pv_a[2];
  int   pv_d[2];

  logic       b_draw, b_clear, s_draw, s_clear;
  logic [9:0] b_x, s_x;
  logic [8:0] b_y, s_y;
  logic [3:0] b_col, s_col;
  logic [2:0] b_sw, s_sw;
  logic       b_busy, b_done, s_busy, s_done;

  brush_stamp_ctrl_if #(.ADDR_W(17)) wb ();
  brush_stamp_ctrl_if #(.ADDR_W(5))  ws ();

  brush_stamp_ctrl #(.CANVAS_W(320), .CANVAS_H(240), .ADDR_W(17), .CLEAR_COLOR(4'h0)) dut_big (
    .clk_in(clk), .rst_in(rst), .draw_req_in(b_draw), .clear_req_in(b_clear),
    .cursor_loc_x(b_x), .cursor_loc_y(b_y), .cursor_color(b_col), .stroke_width(b_sw),
    .wr(wb.master), .busy_out(b_busy), .done_out(b_done)
  );

  brush_stamp_ctrl #(.CANVAS_W(8), .CANVAS_H(4), .ADDR_W(5), .CLEAR_COLOR(4'h5)) dut_small (
    .clk_in(clk), .rst_in(rst), .draw_req_in(s_draw), .clear_req_in(s_clear),
    .cursor_loc_x(s_x), .cursor_loc_y(s_y), .cursor_color(s_col), .stroke_width(s_sw),
    .wr(ws.master), .busy_out(s_busy), .done_out(s_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? qb.size() : qs.size();
  endfunction

  function automatic exp_t qpop(input int sel);
    if (sel == 0) return qb.pop_front();
    return qs.pop_front();
  endfunction

  task automatic push_wr(input int sel, input int a, input int d);
    exp_t e;
    e.done = 1'b0; e.addr = a; e.data = d; e.cyc = 0;
    if (sel == 0) qb.push_back(e); else qs.push_back(e);
  endtask

  task automatic push_done(input int sel, input int c);
    exp_t e;
    e.done = 1'b1; e.addr = 0; e.data = 0; e.cyc = c;
    if (sel == 0) qb.push_back(e); else qs.push_back(e);
  endtask

  task automatic mon(input int sel, input logic v, input logic r, input int a, input int d,
                     input logic dn);
    exp_t e;
    if (pv_stall[sel]) begin
      chk("hold_valid", int'(v), 1);
      chk("hold_addr", a, pv_a[sel]);
      chk("hold_data", d, pv_d[sel]);
    end
    pv_stall[sel] = v && !r;
    pv_a[sel] = a;
    pv_d[sel] = d;
    if (v && r) begin
      if (qsize(sel) == 0) chk("unexpected_write", a, -1);
      else begin
        e = qpop(sel);
        chk("event_kind_write", 0, int'(e.done));
        if (!e.done) begin
          chk("wr_addr", a, e.addr);
          chk("wr_data", d, e.data);
        end
      end
    end
    if (dn) begin
      if (qsize(sel) == 0) chk("unexpected_done", 1, 0);
      else begin
        e = qpop(sel);
        chk("event_kind_done", 1, int'(e.done));
        if (e.done) chk("done_cycle", cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, wb.wr_valid_out, wb.wr_ready_in, int'(wb.wr_addr_out), int'(wb.wr_data_out), b_done);
  always @(negedge clk)
    mon(1, ws.wr_valid_out, ws.wr_ready_in, int'(ws.wr_addr_out), int'(ws.wr_data_out), s_done);

  // Raises the request(s) so they are sampled on the next edge; t0 is the cycle count
  // seen by the monitor right after that accept edge.
  task automatic start_op(input int sel, input bit drw, input bit clr, input int x, input int y,
                          input int col, input int sw, output int t0);
    @(posedge clk); #1;
    t0 = cyc + 1;
    if (sel == 0) begin
      b_draw = drw; b_clear = clr; b_x = 10'(x); b_y = 9'(y); b_col = 4'(col); b_sw = 3'(sw);
    end else begin
      s_draw = drw; s_clear = clr; s_x = 10'(x); s_y = 9'(y); s_col = 4'(col); s_sw = 3'(sw);
    end
  endtask

  task automatic end_op();
    @(posedge clk); #1;
    b_draw = 0; b_clear = 0; s_draw = 0; s_clear = 0;
  endtask

  task automatic drain(input int sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", qsize(sel), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    b_draw = 0; b_clear = 0; b_x = 0; b_y = 0; b_col = 0; b_sw = 0;
    s_draw = 0; s_clear = 0; s_x = 0; s_y = 0; s_col = 0; s_sw = 0;
    wb.wr_ready_in = 1; ws.wr_ready_in = 1;
    pv_stall[0] = 0; pv_stall[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(wb.wr_valid_out), 0);
    chk("rst_addr", int'(wb.wr_addr_out), 0);
    chk("rst_data", int'(wb.wr_data_out), 0);
    chk("rst_busy", int'(b_busy), 0);
    chk("rst_done", int'(b_done), 0);
    chk("rst_small_valid", int'(ws.wr_valid_out), 0);
    rst = 0;

    // single pixel, busy spans exactly one cycle
    start_op(0, 1, 0, 10, 5, 4'hA, 0, t0);
    push_wr(0, 1610, 4'hA);
    push_done(0, t0 + 1);
    end_op();
    chk("single_busy_on", int'(b_busy), 1);
    chk("single_done_low", int'(b_done), 0);
    @(posedge clk); #1;
    chk("single_busy_off", int'(b_busy), 0);
    chk("single_done_pulse", int'(b_done), 1);
    @(posedge clk); #1;
    chk("single_done_once", int'(b_done), 0);
    drain(0, 20);

    // 3x3 stamp
    start_op(0, 1, 0, 100, 50, 4'h3, 2, t0);
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) push_wr(0, 16100 + dy * 320 + dx, 4'h3);
    push_done(0, t0 + 9);
    end_op();
    drain(0, 50);

    // corner clipping: 2 of 16 pixels land
    start_op(0, 1, 0, 318, 239, 4'hC, 3, t0);
    push_wr(0, 76798, 4'hC);
    push_wr(0, 76799, 4'hC);
    push_done(0, t0 + 16);
    end_op();
    drain(0, 50);

    // fully clipped at x0 near the top of the 10-bit range
    start_op(0, 1, 0, 1020, 0, 4'h9, 7, t0);
    push_done(0, t0 + 64);
    end_op();
    drain(0, 100);

    // backpressure on the second pixel for three cycles
    start_op(0, 1, 0, 100, 50, 4'h6, 2, t0);
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) push_wr(0, 16100 + dy * 320 + dx, 4'h6);
    push_done(0, t0 + 12);
    end_op();
    @(posedge clk); #1;
    wb.wr_ready_in = 0;
    repeat (3) @(posedge clk);
    #1;
    wb.wr_ready_in = 1;
    drain(0, 50);

    // asynchronous reset after four writes: no done, outputs cleared at once
    start_op(0, 1, 0, 100, 50, 4'hE, 2, t0);
    push_wr(0, 16100, 4'hE);
    push_wr(0, 16101, 4'hE);
    push_wr(0, 16102, 4'hE);
    push_wr(0, 16420, 4'hE);
    end_op();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", int'(wb.wr_valid_out), 0);
    chk("arst_busy", int'(b_busy), 0);
    chk("arst_addr", int'(wb.wr_addr_out), 0);
    chk("arst_data", int'(wb.wr_data_out), 0);
    @(posedge clk); #1;
    rst = 0;
    chk("arst_writes_seen", qsize(0), 0);
    repeat (4) @(posedge clk);
    #1;
    start_op(0, 1, 0, 10, 5, 4'hA, 0, t0);
    push_wr(0, 1610, 4'hA);
    push_done(0, t0 + 1);
    end_op();
    drain(0, 20);

    // clear sweep on 8x4, with an ignored draw mid-sweep
    start_op(1, 0, 1, 0, 0, 0, 0, t0);
    for (int a = 0; a < 32; a++) push_wr(1, a, 4'h5);
    push_done(1, t0 + 32);
    end_op();
    repeat (5) @(posedge clk);
    #1;
    s_draw = 1; s_x = 1; s_y = 1; s_col = 4'hF; s_sw = 1;
    end_op();
    drain(1, 100);

    // clear during a stamp is deferred until after the stamp's done
    start_op(1, 1, 0, 2, 1, 4'h7, 1, t0);
    push_wr(1, 10, 4'h7);
    push_wr(1, 11, 4'h7);
    push_wr(1, 18, 4'h7);
    push_wr(1, 19, 4'h7);
    push_done(1, t0 + 4);
    for (int a = 0; a < 32; a++) push_wr(1, a, 4'h5);
    push_done(1, t0 + 37);
    end_op();
    s_clear = 1;
    end_op();
    drain(1, 100);

    // simultaneous requests: clear wins, draw is dropped
    start_op(1, 1, 1, 3, 2, 4'hB, 0, t0);
    for (int a = 0; a < 32; a++) push_wr(1, a, 4'h5);
    push_done(1, t0 + 32);
    end_op();
    drain(1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
